// File: rtl/mcycle_sequencer.sv
// mcycle_sequencer
// Machine-cycle / T-state sequencer for the 8085 core. Accepts machine-cycle
// requests from the instruction decoder. Steps T1..T6 with READY-driven wait
// states. Drives the external bus strobes and status lines, plus the
// register-file and instruction-register strobes used by an opcode fetch.
//
// Ports:
//   clk               system clock, rising edge
//   rst               synchronous active-low reset
//   mc_req            machine-cycle request (held with mc_type/mc_long until mc_ack)
//   mc_type[1:0]      00 OF, 01 MR, 10 MW, 11 BI
//   mc_long           OF only: 1 = six T-states, 0 = four
//   ready             external READY, sampled in T2 and TW
//   mc_ack            high during T1 of an accepted cycle
//   mc_done           high during the last T-state of a completed cycle
//   bus_err           one-cycle pulse in the idle cycle after a wait-limit abort
//   tstate[2:0]       0 idle, 1..6 = T1..T6, 7 = TW
//   ale               address latch enable
//   rd_n, wr_n        active-low bus strobes
//   status[1:0]       S1S0: OF 11, MR 10, MW 01, BI 00
//   pc_rw, dreg_rd, dreg_wr, dreg_inc   register-file controls for PC fetch/increment
//   dbus_to_instr_reg load opcode from DBUS into the instruction register
//
// Every output is a flop. The bus/strobe outputs are decoded from the
// next-state values and registered alongside the state, so no input reaches
// an output combinationally and the outputs always line up with tstate.
module mcycle_sequencer #(
    parameter int WAIT_LIMIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mc_req,
    input  logic [1:0] mc_type,
    input  logic       mc_long,
    input  logic       ready,
    output logic       mc_ack,
    output logic       mc_done,
    output logic       bus_err,
    output logic [2:0] tstate,
    output logic       ale,
    output logic       rd_n,
    output logic       wr_n,
    output logic [1:0] status,
    output logic       pc_rw,
    output logic       dreg_rd,
    output logic       dreg_wr,
    output logic       dreg_inc,
    output logic       dbus_to_instr_reg
);

    // The counter must hold WAIT_LIMIT-1 without wrapping; keep at least 4 bits.
    localparam int WCW = (WAIT_LIMIT < 16) ? 4 : $clog2(WAIT_LIMIT + 1);
    // The abort is taken in the TW whose count (before increment) is WAIT_LIMIT-1,
    // i.e. after exactly WAIT_LIMIT wait states.
    localparam logic [WCW-1:0] ABORT_CNT = WCW'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

    localparam logic [1:0] MC_OF = 2'b00;
    localparam logic [1:0] MC_MR = 2'b01;
    localparam logic [1:0] MC_MW = 2'b10;
    localparam logic [1:0] MC_BI = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_T6   = 3'd6,
        ST_TW   = 3'd7
    } state_t;

    typedef struct packed {
        logic       ale;
        logic       rd_n;
        logic       wr_n;
        logic [1:0] status;
        logic       pc_rw;
        logic       dreg_rd;
        logic       dreg_wr;
        logic       dreg_inc;
        logic       ir_load;
        logic       mc_ack;
        logic       mc_done;
    } outs_t;

    state_t         state_reg, state_next;
    logic [1:0]     type_reg, type_next;
    logic           long_reg, long_next;
    logic [WCW-1:0] wait_cnt_reg, wait_cnt_next;
    logic           bus_err_reg, bus_err_next;
    outs_t          outs_reg;

    function automatic logic is_last(state_t st, logic [1:0] ty, logic lg);
        return (st == ST_T3 && ty != MC_OF) ||
               (st == ST_T4 && ty == MC_OF && !lg) ||
               (st == ST_T6);
    endfunction

    function automatic outs_t decode(state_t st, logic [1:0] ty, logic lg);
        outs_t o;
        logic  is_of;
        logic  bus_phase;
        o         = '0;
        o.rd_n    = 1'b1;
        o.wr_n    = 1'b1;
        is_of     = (ty == MC_OF);
        bus_phase = (st == ST_T2) || (st == ST_TW) || (st == ST_T3);
        if (st != ST_IDLE) begin
            // S1S0 codes are the bitwise complement of the type encoding.
            o.status   = ~ty;
            o.ale      = (st == ST_T1) && (ty != MC_BI);
            o.rd_n     = !(bus_phase && (ty == MC_OF || ty == MC_MR));
            o.wr_n     = !(bus_phase && ty == MC_MW);
            o.pc_rw    = is_of && (st == ST_T1 || st == ST_T2);
            o.dreg_rd  = is_of && (st == ST_T1);
            o.dreg_wr  = is_of && (st == ST_T2);
            o.dreg_inc = is_of && (st == ST_T2);
            o.ir_load  = is_of && (st == ST_T3);
            o.mc_ack   = (st == ST_T1);
            o.mc_done  = is_last(st, ty, lg);
        end
        return o;
    endfunction

    always_comb begin
        state_next    = state_reg;
        type_next     = type_reg;
        long_next     = long_reg;
        wait_cnt_next = wait_cnt_reg;
        bus_err_next  = 1'b0;

        case (state_reg)
            ST_T1: state_next = ST_T2;
            ST_T2: state_next = (type_reg != MC_BI && !ready) ? ST_TW : ST_T3;
            ST_TW: begin
                if (wait_cnt_reg != '1)
                    wait_cnt_next = wait_cnt_reg + WCW'(1);
                if (ready) begin
                    state_next = ST_T3;
                end else if (WAIT_LIMIT != 0 && wait_cnt_reg == ABORT_CNT) begin
                    state_next   = ST_IDLE;
                    bus_err_next = 1'b1;
                end
            end
            ST_T3: if (type_reg == MC_OF) state_next = ST_T4;
            ST_T4: if (long_reg) state_next = ST_T5;
            ST_T5: state_next = ST_T6;
            default: ;
        endcase

        // Requests are only sampled in idle or in the last T-state; this lets a
        // new cycle start straight after the previous one with no idle gap.
        if (state_reg == ST_IDLE || is_last(state_reg, type_reg, long_reg)) begin
            if (mc_req) begin
                state_next    = ST_T1;
                type_next     = mc_type;
                long_next     = mc_long;
                wait_cnt_next = '0;
            end else begin
                state_next    = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            type_reg     <= MC_OF;
            long_reg     <= 1'b0;
            wait_cnt_reg <= '0;
            bus_err_reg  <= 1'b0;
            outs_reg     <= decode(ST_IDLE, MC_OF, 1'b0);
        end else begin
            state_reg    <= state_next;
            type_reg     <= type_next;
            long_reg     <= long_next;
            wait_cnt_reg <= wait_cnt_next;
            bus_err_reg  <= bus_err_next;
            outs_reg     <= decode(state_next, type_next, long_next);
        end
    end

    assign tstate            = state_reg;
    assign bus_err           = bus_err_reg;
    assign ale               = outs_reg.ale;
    assign rd_n              = outs_reg.rd_n;
    assign wr_n              = outs_reg.wr_n;
    assign status            = outs_reg.status;
    assign pc_rw             = outs_reg.pc_rw;
    assign dreg_rd           = outs_reg.dreg_rd;
    assign dreg_wr           = outs_reg.dreg_wr;
    assign dreg_inc          = outs_reg.dreg_inc;
    assign dbus_to_instr_reg = outs_reg.ir_load;
    assign mc_ack            = outs_reg.mc_ack;
    assign mc_done           = outs_reg.mc_done;

endmodule

// File: tb/tb_mcycle_sequencer.sv
// Testbench for mcycle_sequencer (WAIT_LIMIT = 3).
// Each scenario describes machine cycles as {type, long, waits, gap}; a
// reference model expands them into the expected per-cycle T-state timeline
// and bus/strobe values, the bench drives req/ready from that timeline and
// compares every cycle of the DUT outputs against it.
module tb_mcycle_sequencer;

    localparam int L = 3;
    localparam logic [1:0] MC_OF = 2'b00;
    localparam logic [1:0] MC_MR = 2'b01;
    localparam logic [1:0] MC_MW = 2'b10;
    localparam logic [1:0] MC_BI = 2'b11;
    // tstate 0, ale 0, rd_n 1, wr_n 1, status 00, all strobes/handshakes 0
    localparam logic [15:0] RESET_VEC = {3'd0, 1'b0, 1'b1, 1'b1, 2'b00, 8'h00};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mc_req = 1'b0;
    logic [1:0] mc_type = 2'b00;
    logic       mc_long = 1'b0;
    logic       ready = 1'b1;
    logic       mc_ack, mc_done, bus_err, ale, rd_n, wr_n;
    logic [2:0] tstate;
    logic [1:0] status;
    logic       pc_rw, dreg_rd, dreg_wr, dreg_inc, dbus_to_instr_reg;

    int checks = 0;
    int failures = 0;

    // Tiny register file / IR driven by the DUT strobes.
    logic [7:0]  dbus = 8'h00;
    logic [7:0]  ir_model = 8'h00;
    logic [15:0] pc_model = 16'h1000;

    typedef struct {
        logic [1:0] ty;
        logic       lg;
        int         waits;
        int         gap;
    } txn_t;

    typedef struct {
        logic [2:0] ts;
        logic [1:0] ty;
        logic       lg;
        logic       done;
        logic       err;
        logic       req;
        logic [1:0] rq_ty;
        logic       rq_lg;
        logic       rdy;
    } cyc_t;

    txn_t        txq[$];
    cyc_t        tl[$];
    logic [15:0] obs[$];

    mcycle_sequencer #(.WAIT_LIMIT(L)) dut (
        .clk(clk), .rst(rst), .mc_req(mc_req), .mc_type(mc_type), .mc_long(mc_long),
        .ready(ready), .mc_ack(mc_ack), .mc_done(mc_done), .bus_err(bus_err),
        .tstate(tstate), .ale(ale), .rd_n(rd_n), .wr_n(wr_n), .status(status),
        .pc_rw(pc_rw), .dreg_rd(dreg_rd), .dreg_wr(dreg_wr), .dreg_inc(dreg_inc),
        .dbus_to_instr_reg(dbus_to_instr_reg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dbus_to_instr_reg) ir_model <= dbus;
        if (dreg_wr && dreg_inc) pc_model <= pc_model + 16'd1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] observed();
        return {tstate, ale, rd_n, wr_n, status, pc_rw, dreg_rd, dreg_wr, dreg_inc,
                dbus_to_instr_reg, mc_ack, mc_done, bus_err};
    endfunction

    // Expected outputs for one cycle of the timeline, straight from the
    // per-T-state rules of the bus protocol.
    function automatic logic [15:0] expect_out(cyc_t c);
        logic       of_c, bus;
        logic [1:0] st;
        of_c = (c.ty == MC_OF);
        bus  = (c.ts == 3'd2) || (c.ts == 3'd7) || (c.ts == 3'd3);
        st   = 2'b00;
        if (c.ts != 3'd0) begin
            case (c.ty)
                MC_OF:   st = 2'b11;
                MC_MR:   st = 2'b10;
                MC_MW:   st = 2'b01;
                default: st = 2'b00;
            endcase
        end
        return {c.ts,
                (c.ts == 3'd1) && (c.ty != MC_BI),
                !(bus && (c.ty == MC_OF || c.ty == MC_MR)),
                !(bus && c.ty == MC_MW),
                st,
                of_c && (c.ts == 3'd1 || c.ts == 3'd2),
                of_c && (c.ts == 3'd1),
                of_c && (c.ts == 3'd2),
                of_c && (c.ts == 3'd2),
                of_c && (c.ts == 3'd3),
                (c.ts == 3'd1),
                c.done,
                c.err};
    endfunction

    task automatic push_cyc(input logic [2:0] ts, input logic [1:0] ty, input logic lg,
                            input logic err);
        cyc_t c;
        c = '{ts: ts, ty: ty, lg: lg, done: 1'b0, err: err, req: 1'b0,
              rq_ty: 2'b00, rq_lg: 1'b0, rdy: 1'b1};
        tl.push_back(c);
    endtask

    // Expand txq into a per-cycle timeline.
    task automatic build_timeline();
        cyc_t c;
        int   w;
        int   n;
        tl.delete();
        push_cyc(3'd0, 2'b00, 1'b0, 1'b0);
        foreach (txq[i]) begin
            for (int g = 0; g < txq[i].gap; g++) push_cyc(3'd0, 2'b00, 1'b0, 1'b0);
            n = tl.size();
            c = tl[n-1];
            c.req = 1'b1; c.rq_ty = txq[i].ty; c.rq_lg = txq[i].lg;
            tl[n-1] = c;
            w = (txq[i].ty == MC_BI) ? 0 : txq[i].waits;
            push_cyc(3'd1, txq[i].ty, txq[i].lg, 1'b0);
            push_cyc(3'd2, txq[i].ty, txq[i].lg, 1'b0);
            for (int j = 0; j < w && j < L; j++) push_cyc(3'd7, txq[i].ty, txq[i].lg, 1'b0);
            if (w >= L) begin
                push_cyc(3'd0, 2'b00, 1'b0, 1'b1);
            end else begin
                push_cyc(3'd3, txq[i].ty, txq[i].lg, 1'b0);
                if (txq[i].ty == MC_OF) push_cyc(3'd4, txq[i].ty, txq[i].lg, 1'b0);
                if (txq[i].ty == MC_OF && txq[i].lg) begin
                    push_cyc(3'd5, txq[i].ty, txq[i].lg, 1'b0);
                    push_cyc(3'd6, txq[i].ty, txq[i].lg, 1'b0);
                end
                n = tl.size();
                c = tl[n-1]; c.done = 1'b1; tl[n-1] = c;
            end
        end
        push_cyc(3'd0, 2'b00, 1'b0, 1'b0);
        push_cyc(3'd0, 2'b00, 1'b0, 1'b0);
        // ready low exactly where a wait state must follow; random elsewhere.
        for (int k = 0; k < tl.size(); k++) begin
            c = tl[k];
            if ((c.ts == 3'd2 || c.ts == 3'd7) && c.ty != MC_BI && k + 1 < tl.size())
                c.rdy = !(tl[k+1].ts == 3'd7 || tl[k+1].ts == 3'd0);
            else
                c.rdy = 1'($urandom);
            tl[k] = c;
        end
    endtask

    // Drive the timeline's inputs and capture outputs once per cycle.
    task automatic run_timeline();
        obs.delete();
        foreach (tl[k]) begin
            @(posedge clk); #1;
            mc_req  = tl[k].req;
            mc_type = tl[k].req ? tl[k].rq_ty : 2'($urandom);
            mc_long = tl[k].req ? tl[k].rq_lg : 1'($urandom);
            ready   = tl[k].rdy;
            @(negedge clk);
            obs.push_back(observed());
        end
        mc_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; mc_req = 1'b1; mc_type = MC_OF; mc_long = 1'b0; ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (observed() !== RESET_VEC) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, observed(), RESET_VEC);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tstate, mc_ack, status, ale} !== {3'd1, 1'b1, 2'b11, 1'b1}) begin
            failures++;
            $display("FAIL reset_release_t1 got=%b exp=%b", {tstate, mc_ack, status, ale},
                     {3'd1, 1'b1, 2'b11, 1'b1});
        end
        mc_req = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_short_of();
        logic [15:0] pc_start;
        pc_start = pc_model;
        dbus = 8'h43;
        txq.delete();
        txq.push_back('{ty: MC_OF, lg: 1'b0, waits: 0, gap: 0});
        build_timeline();
        run_timeline();
        foreach (tl[k]) begin
            checks++;
            if (obs[k] !== expect_out(tl[k])) begin
                failures++;
                $display("FAIL short_of cyc=%0d got=%h exp=%h", k, obs[k], expect_out(tl[k]));
            end
        end
        checks++;
        if (ir_model !== 8'h43) begin
            failures++;
            $display("FAIL short_of_ir got=%h exp=43", ir_model);
        end
        checks++;
        if (pc_model !== pc_start + 16'd1) begin
            failures++;
            $display("FAIL short_of_pc got=%h exp=%h", pc_model, pc_start + 16'd1);
        end
    endtask

    task automatic test_b2b_long_of_mw();
        txq.delete();
        txq.push_back('{ty: MC_OF, lg: 1'b1, waits: 0, gap: 0});
        txq.push_back('{ty: MC_MW, lg: 1'b0, waits: 0, gap: 0});
        build_timeline();
        run_timeline();
        foreach (tl[k]) begin
            checks++;
            if (obs[k] !== expect_out(tl[k])) begin
                failures++;
                $display("FAIL b2b_of_mw cyc=%0d got=%h exp=%h", k, obs[k], expect_out(tl[k]));
            end
        end
    endtask

    task automatic test_mr_wait();
        txq.delete();
        txq.push_back('{ty: MC_MR, lg: 1'b0, waits: 2, gap: 1});
        build_timeline();
        run_timeline();
        foreach (tl[k]) begin
            checks++;
            if (obs[k] !== expect_out(tl[k])) begin
                failures++;
                $display("FAIL mr_wait cyc=%0d got=%h exp=%h", k, obs[k], expect_out(tl[k]));
            end
        end
    endtask

    task automatic test_wait_abort();
        txq.delete();
        txq.push_back('{ty: MC_MW, lg: 1'b0, waits: L, gap: 0});
        txq.push_back('{ty: MC_BI, lg: 1'b1, waits: 0, gap: 0});
        build_timeline();
        run_timeline();
        foreach (tl[k]) begin
            checks++;
            if (obs[k] !== expect_out(tl[k])) begin
                failures++;
                $display("FAIL wait_abort cyc=%0d got=%h exp=%h", k, obs[k], expect_out(tl[k]));
            end
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        mc_req = 1'b1; mc_type = MC_MR; mc_long = 1'b0; ready = 1'b0;
        @(posedge clk); #1;
        mc_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tstate == 3'd7) break;
        end
        checks++;
        if (tstate !== 3'd7) begin
            failures++;
            $display("FAIL reset_mid_reach_tw got=%0d exp=7", tstate);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (observed() !== RESET_VEC) begin
            failures++;
            $display("FAIL reset_mid got=%h exp=%h", observed(), RESET_VEC);
        end
        rst = 1'b1; ready = 1'b1;
        txq.delete();
        txq.push_back('{ty: MC_MR, lg: 1'b0, waits: 2, gap: 0});
        build_timeline();
        run_timeline();
        foreach (tl[k]) begin
            checks++;
            if (obs[k] !== expect_out(tl[k])) begin
                failures++;
                $display("FAIL reset_mid_after cyc=%0d got=%h exp=%h", k, obs[k], expect_out(tl[k]));
            end
        end
    endtask

    task automatic test_random();
        txn_t t;
        txq.delete();
        for (int i = 0; i < 40; i++) begin
            t.ty    = 2'($urandom);
            t.lg    = 1'($urandom);
            t.waits = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            t.gap   = int'($urandom_range(0, 2));
            txq.push_back(t);
        end
        build_timeline();
        run_timeline();
        foreach (tl[k]) begin
            checks++;
            if (obs[k] !== expect_out(tl[k])) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", k, obs[k], expect_out(tl[k]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_short_of();
        test_b2b_long_of_mw();
        test_mr_wait();
        test_wait_abort();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
